kan_coeff_loader: RTL and testbench

// Writer side of the KAN PE coefficient-memory port. Accepts a valid/ready word stream from the host/DMA.

---
 rtl/kan_coeff_loader.sv | 149 ++++++++++++++
 tb/tb_kan_coeff_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kan_coeff_loader.sv
// Streams a spline-coefficient + knot image into one KAN PE memory, checking framing and knot order.
// Latency: each accepted word is written to the PE one cycle after its handshake; done coincides with the final write.
// Backpressure: s_ready is registered, high only while loading; it drops on error, completion or abort.
module kan_coeff_loader #(
  parameter int DATA_WIDTH      = 16,
  parameter int COEFF_WIDTH     = 16,
  parameter int GRID_SIZE       = 8,
  parameter int NUM_INPUTS      = 4,
  parameter int BRAM_ADDR_WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_last,
  output logic [BRAM_ADDR_WIDTH-1:0] coeff_addr,
  output logic                       coeff_we,
  output logic [COEFF_WIDTH-1:0]     coeff_data_in,
  output logic                       pe_hold,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       knot_order_err,
  output logic [15:0]                checksum
);

  // Image geometry: coefficient block, then one knot segment per input.
  localparam int CW    = NUM_INPUTS * GRID_SIZE;
  localparam int KW    = NUM_INPUTS * (GRID_SIZE + 4);
  localparam int TOT   = CW + KW;
  localparam int SEG   = GRID_SIZE + 4;
  localparam int SEG_W = $clog2(SEG);

  localparam logic [BRAM_ADDR_WIDTH-1:0] COEFF_LAST = BRAM_ADDR_WIDTH'(CW - 1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] IMG_LAST   = BRAM_ADDR_WIDTH'(TOT - 1);
  localparam logic [SEG_W-1:0]           SEG_LAST   = SEG_W'(SEG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COEFF,
    S_KNOT,
    S_DONE,
    S_ERR
  } state_t;

  state_t                     state, next_state;
  logic                       beat;        // word accepted this cycle
  logic                       load_start;  // a load (re)starts this cycle
  logic                       knot_dec;    // current knot is below its predecessor
  logic [BRAM_ADDR_WIDTH-1:0] word_cnt;
  logic [SEG_W-1:0]           seg_pos;     // position of the current knot inside its segment
  logic [DATA_WIDTH-1:0]      prev_knot;

  // A word arriving in the same cycle as abort is dropped.
  assign beat = s_valid & s_ready & ~abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode: abort wins, then framing checks on each beat.
  always_comb begin
    next_state = state;
    load_start = 1'b0;
    knot_dec   = (state == S_KNOT) && (seg_pos != '0) && (s_data < prev_knot);
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            next_state = S_COEFF;
            load_start = 1'b1;
          end
        end
        S_COEFF, S_KNOT: begin
          if (beat) begin
            if (word_cnt == IMG_LAST)
              next_state = s_last ? S_DONE : S_ERR;
            else if (s_last)
              next_state = S_ERR;
            else if ((state == S_COEFF) && (word_cnt == COEFF_LAST))
              next_state = S_KNOT;
          end
        end
        S_DONE: next_state = S_IDLE;
        S_ERR: begin
          if (start) begin
            next_state = S_COEFF;
            load_start = 1'b1;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Registered outputs, write port and per-load bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready        <= 1'b0;
      pe_hold        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      knot_order_err <= 1'b0;
      checksum       <= '0;
      coeff_we       <= 1'b0;
      coeff_addr     <= '0;
      coeff_data_in  <= '0;
      word_cnt       <= '0;
      seg_pos        <= '0;
      prev_knot      <= '0;
    end else begin
      s_ready  <= (next_state == S_COEFF) || (next_state == S_KNOT);
      pe_hold  <= (next_state != S_IDLE);
      busy     <= (next_state != S_IDLE);
      done     <= (next_state == S_DONE);
      coeff_we <= beat;
      if (beat) begin
        coeff_addr    <= word_cnt;
        coeff_data_in <= COEFF_WIDTH'(s_data);
      end
      if (load_start) begin
        word_cnt       <= '0;
        seg_pos        <= '0;
        prev_knot      <= '0;
        checksum       <= '0;
        error          <= 1'b0;
        knot_order_err <= 1'b0;
      end else if (beat) begin
        word_cnt <= word_cnt + BRAM_ADDR_WIDTH'(1);
        checksum <= checksum + 16'(s_data);
        if (state == S_KNOT) begin
          prev_knot <= s_data;
          seg_pos   <= (seg_pos == SEG_LAST) ? '0 : seg_pos + SEG_W'(1);
          if (knot_dec) knot_order_err <= 1'b1;
        end
      end
      if (next_state == S_ERR) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kan_coeff_loader.sv
// Bench for kan_coeff_loader: random images driven over the valid/ready stream.
// Expected writes, checksum, knot-order flag and completion come from an image-level model.
// Inputs change 1 ns after the rising edge; outputs are observed on the falling edge or 1 ns after rising.
`timescale 1ns/1ps
module tb_kan_coeff_loader;

  localparam int CW  = 32;
  localparam int SEG = 12;
  localparam int TOT = 80;

  typedef logic [15:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, s_valid, s_last;
  logic [15:0] s_data;
  logic        s_ready, coeff_we, pe_hold, busy, done, error, knot_order_err;
  logic [8:0]  coeff_addr;
  logic [15:0] coeff_data_in, checksum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kan_coeff_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .coeff_addr(coeff_addr), .coeff_we(coeff_we), .coeff_data_in(coeff_data_in),
    .pe_hold(pe_hold), .busy(busy), .done(done), .error(error),
    .knot_order_err(knot_order_err), .checksum(checksum)
  );

  // Write log of the PE memory port and done-pulse counters.
  logic [8:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  int done_cnt      = 0;
  int done_with_wr  = 0;

  always @(negedge clk) begin
    if (coeff_we) begin
      wr_addr.push_back(coeff_addr);
      wr_data.push_back(coeff_data_in);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (coeff_we && coeff_addr == 9'd79) done_with_wr <= done_with_wr + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic wq_t make_image(input int kind);
    wq_t w;
    logic [15:0] v = 16'd0;
    for (int i = 0; i < TOT; i++) begin
      if (kind == 0) w.push_back(16'(i + 1));
      else if (i < CW || kind == 1) w.push_back(16'($urandom));
      else begin
        if ((i - CW) % SEG == 0) v = 16'($urandom_range(0, 2000));
        else                     v = v + 16'($urandom_range(0, 50));
        w.push_back(v);
      end
    end
    return w;
  endfunction

  function automatic logic [15:0] model_sum(input wq_t w);
    logic [15:0] s = 16'd0;
    foreach (w[i]) s = s + w[i];
    return s;
  endfunction

  function automatic bit model_kerr(input wq_t w);
    for (int k = CW; k < w.size(); k++)
      if ((k - CW) % SEG != 0 && w[k] < w[k-1]) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_stream(input string name, input wq_t w, input int last_at,
                             input int gap_pct, output int sent);
    int i = 0;
    int guard = 0;
    while (i < w.size() && guard < 3000) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        s_valid = 1'b0; s_last = 1'b0;
      end else begin
        s_valid = 1'b1; s_data = w[i]; s_last = (i == last_at);
      end
      @(negedge clk);
      if (s_valid && s_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    sent = i;
    checks++;
    if (guard >= 3000) begin
      failures++;
      $display("FAIL %s stream_timeout: accepted %0d words, required %0d", name, i, w.size());
    end
  endtask

  // Full load scenario: start, stream the image, then compare against the model.
  task automatic test_load(input string name, input wq_t w, input int last_at, input int gap);
    int  n, bad, first_bad;
    int  wb = wr_addr.size();
    int  db = done_cnt;
    int  dw = done_with_wr;
    bit  exp_done;
    do_start();
    checks++;
    if (error !== 1'b0 || knot_order_err !== 1'b0 || busy !== 1'b1 || pe_hold !== 1'b1 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s after_start: err=%b kerr=%b busy=%b hold=%b rdy=%b, required 0 0 1 1 1",
               name, error, knot_order_err, busy, pe_hold, s_ready);
    end
    send_stream(name, w, last_at, gap, n);
    repeat (8) @(posedge clk);
    #1;
    exp_done = (w.size() == TOT) && (last_at == TOT - 1);
    checks++;
    if (wr_addr.size() - wb !== w.size()) begin
      failures++;
      $display("FAIL %s write_count: got %0d required %0d", name, wr_addr.size() - wb, w.size());
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i < w.size() && wb + i < wr_addr.size(); i++) begin
      if (wr_addr[wb+i] !== 9'(i) || wr_data[wb+i] !== w[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s write_seq: %0d bad, first #%0d addr=%0d data=%h required addr=%0d data=%h",
               name, bad, first_bad, wr_addr[wb+first_bad], wr_data[wb+first_bad], first_bad, w[first_bad]);
    end
    checks++;
    if (done_cnt - db !== (exp_done ? 1 : 0) || done_with_wr - dw !== (exp_done ? 1 : 0)) begin
      failures++;
      $display("FAIL %s done: pulses=%0d with_last_write=%0d required %0d", name,
               done_cnt - db, done_with_wr - dw, exp_done ? 1 : 0);
    end
    checks++;
    if (error !== !exp_done) begin
      failures++;
      $display("FAIL %s error: got %b required %b", name, error, !exp_done);
    end
    checks++;
    if (knot_order_err !== model_kerr(w)) begin
      failures++;
      $display("FAIL %s knot_order_err: got %b required %b", name, knot_order_err, model_kerr(w));
    end
    checks++;
    if (checksum !== model_sum(w)) begin
      failures++;
      $display("FAIL %s checksum: got %0d required %0d", name, checksum, model_sum(w));
    end
    checks++;
    if (busy !== !exp_done || pe_hold !== !exp_done || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s final_state: busy=%b hold=%b rdy=%b required %b %b 0",
               name, busy, pe_hold, s_ready, !exp_done, !exp_done);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    checks++;
    if ({s_ready, coeff_addr, coeff_we, coeff_data_in, pe_hold, busy, done, error, knot_order_err, checksum} !== 48'd0) begin
      failures++;
      $display("FAIL reset_values: outputs=%h required 0",
               {s_ready, coeff_addr, coeff_we, coeff_data_in, pe_hold, busy, done, error, knot_order_err, checksum});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_full_load();
    test_load("count", make_image(0), TOT - 1, 0);
    checks++;
    if (checksum !== 16'd3240) begin
      failures++;
      $display("FAIL count_checksum_const: got %0d required 3240", checksum);
    end
  endtask

  task automatic test_random_gaps();
    wq_t w = make_image(0);
    test_load("gaps_count", w, TOT - 1, 40);
    test_load("gaps_rand", make_image(1), TOT - 1, 30);
  endtask

  task automatic test_early_last();
    wq_t w = make_image(2);
    wq_t part;
    for (int i = 0; i < 40; i++) part.push_back(w[i]);
    test_load("early_last", part, 39, 20);
  endtask

  task automatic test_missing_last();
    test_load("no_last", make_image(2), -1, 20);
    test_load("reload_after_err", make_image(2), TOT - 1, 10);
  endtask

  task automatic test_knot_order();
    wq_t w = make_image(0);
    logic [15:0] seg0[12] = '{16'd0, 16'd10, 16'd5, 16'd20, 16'd30, 16'd40,
                              16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd100};
    for (int j = 0; j < SEG; j++) w[CW+j] = seg0[j];
    for (int k = CW + SEG; k < TOT; k++) w[k] = 16'(((k - CW) % SEG) * 3);
    test_load("knot_order", w, TOT - 1, 0);
    test_load("knot_sorted", make_image(2), TOT - 1, 15);
  endtask

  task automatic test_reset_midload();
    wq_t w = make_image(1);
    wq_t part;
    int  n;
    for (int i = 0; i < 20; i++) part.push_back(w[i]);
    do_start();
    send_stream("midload", part, -1, 0, n);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, coeff_addr, coeff_we, coeff_data_in, pe_hold, busy, done, error, knot_order_err, checksum} !== 48'd0) begin
      failures++;
      $display("FAIL midload_reset: outputs=%h required 0",
               {s_ready, coeff_addr, coeff_we, coeff_data_in, pe_hold, busy, done, error, knot_order_err, checksum});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_load("after_reset", make_image(2), TOT - 1, 10);
  endtask

  task automatic test_abort();
    wq_t w = make_image(1);
    wq_t part;
    int  n;
    int  wb = wr_addr.size();
    for (int i = 0; i < 10; i++) part.push_back(w[i]);
    do_start();
    send_stream("abort", part, -1, 0, n);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (pe_hold !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_release: hold=%b busy=%b rdy=%b required 0 0 0", pe_hold, busy, s_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_addr.size() - wb !== 10 || wr_addr[wr_addr.size()-1] !== 9'd9) begin
      failures++;
      $display("FAIL abort_writes: count=%0d last_addr=%0d required 10 and 9",
               wr_addr.size() - wb, wr_addr[wr_addr.size()-1]);
    end
    checks++;
    if (checksum !== model_sum(part) || error !== 1'b0) begin
      failures++;
      $display("FAIL abort_retained: checksum=%0d err=%b required %0d 0", checksum, error, model_sum(part));
    end
    test_load("after_abort", make_image(2), TOT - 1, 10);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++)
      test_load("b2b", make_image(1 + (r % 2)), TOT - 1, $urandom_range(0, 50));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_data = 16'd0; s_last = 1'b0;
    test_reset();
    test_full_load();
    test_random_gaps();
    test_early_last();
    test_missing_last();
    test_knot_order();
    test_reset_midload();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
